// File: rtl/word_buffer.sv
// Packs 4-lane words into a 2**POINTER_WIDTH FIFO; 1-cycle strobe-to-valid latency, no empty bypass.
// Valid/ready output; strobes arriving while full with no pop are dropped and counted (saturating).
module word_buffer #(
  parameter int DATA_WIDTH    = 8,
  parameter int POINTER_WIDTH = 4
) (
  input  logic                         receiver_clock,
  input  logic                         reset,
  input  logic                         data_out_ready,
  input  logic [DATA_WIDTH-1:0]        data_out [3:0],
  output logic                         word_out_valid,
  input  logic                         word_out_ready,
  output logic [4*DATA_WIDTH-1:0]      word_out,
  output logic [POINTER_WIDTH:0]       words_used,
  output logic [15:0]                  overflow_count
);

  localparam int DEPTH = 2 ** POINTER_WIDTH;
  localparam int WW    = 4 * DATA_WIDTH;
  localparam logic [POINTER_WIDTH:0] CNT_MAX = (POINTER_WIDTH+1)'(DEPTH);

  logic [WW-1:0]            mem_q [DEPTH];
  logic [POINTER_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [POINTER_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [POINTER_WIDTH:0]   count_q, count_d;
  logic [15:0]              ovf_q, ovf_d;

  logic          full, pop, push, drop;
  logic [WW-1:0] packed_word;

  assign packed_word = {data_out[3], data_out[2], data_out[1], data_out[0]};
  assign full        = (count_q == CNT_MAX);
  assign pop         = word_out_valid && word_out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign push        = data_out_ready && (!full || pop);
  assign drop        = data_out_ready && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + POINTER_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + POINTER_WIDTH'(1);
    if (push && !pop)      count_d = count_q + (POINTER_WIDTH+1)'(1);
    else if (pop && !push) count_d = count_q - (POINTER_WIDTH+1)'(1);
    if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge receiver_clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push) mem_q[wr_ptr_q] <= packed_word;
    end
  end

  assign word_out_valid = (count_q != '0);
  assign word_out       = mem_q[rd_ptr_q];
  assign words_used     = count_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_word_buffer.sv
// Scoreboard bench for word_buffer: queue model tracks accepted words, pops compared on handshake.
module tb_word_buffer;

  logic        clk;
  logic        reset;
  logic        data_out_ready;
  logic [7:0]  data_out [3:0];
  logic        word_out_valid;
  logic        word_out_ready;
  logic [31:0] word_out;
  logic [4:0]  words_used;
  logic [15:0] overflow_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q [$];
  logic [15:0] ovf_m;

  word_buffer #(.DATA_WIDTH(8), .POINTER_WIDTH(4)) dut (
    .receiver_clock (clk),
    .reset          (reset),
    .data_out_ready (data_out_ready),
    .data_out       (data_out),
    .word_out_valid (word_out_valid),
    .word_out_ready (word_out_ready),
    .word_out       (word_out),
    .words_used     (words_used),
    .overflow_count (overflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic [31:0] w, input logic r);
    data_out_ready = s;
    for (int i = 0; i < 4; i++) data_out[i] = w[8*i +: 8];
    word_out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
  endtask

  // Model runs mid-cycle, when inputs are settled and outputs reflect the last edge.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_valid", word_out_valid, 1'b0);
      check("rst_word",  word_out, 32'h0);
      check("rst_used",  words_used, 5'd0);
      check("rst_ovf",   overflow_count, 16'h0);
      exp_q.delete();
      ovf_m = 16'h0;
    end else begin
      check("valid", word_out_valid, exp_q.size() != 0);
      check("used",  words_used, exp_q.size());
      check("ovf",   overflow_count, ovf_m);
      if (exp_q.size() != 0 && word_out_ready)
        check("data", word_out, exp_q.pop_front());
      if (data_out_ready) begin
        if (exp_q.size() < 16)
          exp_q.push_back({data_out[3], data_out[2], data_out[1], data_out[0]});
        else if (ovf_m != 16'hFFFF)
          ovf_m = ovf_m + 16'd1;
      end
    end
  end

  initial begin
    reset          = 1'b1;
    data_out_ready = 1'b0;
    word_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) data_out[i] = 8'h0;
    ovf_m = 16'h0;

    // Reset held with strobes active
    for (int i = 0; i < 3; i++) step(1'b1, 32'hDEADBEEF, 1'b1);
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    check("post_rst_used", words_used, 5'd0);

    // Single word, held while not ready
    step(1'b1, 32'h04030201, 1'b0);
    check("single_valid", word_out_valid, 1'b1);
    check("single_word",  word_out, 32'h04030201);
    check("single_used",  words_used, 5'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b0);
      check("single_hold", word_out, 32'h04030201);
    end
    step(1'b0, 32'h0, 1'b1);
    check("single_popped", words_used, 5'd0);

    // Fill and overflow
    for (int i = 0; i < 18; i++) step(1'b1, 32'(i), 1'b0);
    check("fill_used", words_used, 5'd16);
    check("fill_ovf",  overflow_count, 16'd2);
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1);
    check("drain_used", words_used, 5'd0);

    // Full with simultaneous push and pop across pointer wrap
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h200 + 32'(i), 1'b1);
      check("pp_used", words_used, 5'd16);
    end
    check("pp_ovf", overflow_count, 16'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1);

    // Overflow counter saturation
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 32'h500 + 32'(i), 1'b0);
    for (int i = 0; i < 65540; i++) step(1'b1, 32'hAAAA0000, 1'b0);
    check("sat_ovf",  overflow_count, 16'hFFFF);
    check("sat_used", words_used, 5'd16);

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 32'h300 + 32'(i), 1'b0);
    data_out_ready = 1'b0;
    check("pre_arst_used", words_used, 5'd7);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", word_out_valid, 1'b0);
    check("arst_used",  words_used, 5'd0);
    check("arst_word",  word_out, 32'h0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(i), 1'b0);
    check("new_head", word_out, 32'h400);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    check("final_used", words_used, 5'd0);
    step(1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/word_buffer.md
# word_buffer

Downstream stage of `deserializer`, in the `receiver_clock` domain. Captures each 4-lane word presented with `data_out_ready` and packs it little-endian into one `4*DATA_WIDTH`-bit word. Queues the words in a `2**POINTER_WIDTH`-entry FIFO and presents them to the consumer over a valid/ready handshake. Words arriving when the FIFO is full and no entry frees that cycle are dropped and counted.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of one lane; output word is `4*DATA_WIDTH` bits.
- `POINTER_WIDTH`, default 4: FIFO depth is `2**POINTER_WIDTH` words.

Ports:
- `receiver_clock`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `data_out_ready`  input  1  single-cycle strobe: lanes valid this cycle.
- `data_out`  input  `[DATA_WIDTH-1:0] x [3:0]`  unpacked lanes from `deserializer`.
- `word_out_valid`  output  1  FIFO non-empty; `word_out` holds the head entry.
- `word_out_ready`  input  1  consumer accepts the head when `word_out_valid` is also high.
- `word_out`  output  `4*DATA_WIDTH`  head word, packed as `{data_out[3], data_out[2], data_out[1], data_out[0]}`.
- `words_used`  output  `POINTER_WIDTH+1`  current occupancy, 0 to `2**POINTER_WIDTH`.
- `overflow_count`  output  16  number of dropped words, saturating.

## Operation
- Storage: array of `2**POINTER_WIDTH` words.
  - Write pointer and read pointer are each `POINTER_WIDTH` bits and wrap naturally.
  - Occupancy is a separate `POINTER_WIDTH+1`-bit counter.
- Pop: `pop = word_out_valid && word_out_ready`.
- Push: `push = data_out_ready && (words_used < 2**POINTER_WIDTH || pop)`.
  - The word is written at the write pointer, then the write pointer increments.
- Drop: `data_out_ready` high while full and `pop` low.
  - Nothing is written and no pointer moves.
  - `overflow_count` increments by 1 and saturates at 16'hFFFF.
- Pop effect: the read pointer increments.
- Occupancy update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push with pop, and on neither.
- `word_out_valid` = (`words_used != 0`).
- `word_out` = storage at the read pointer (combinational read of registered state).
  - Stable while valid is high and ready is low.
  - Value is don't-care while valid is low, except at reset.
- `word_out_ready` while empty has no effect.
- No other state machine. The block has two occupancy regimes:
  - EMPTY (`words_used == 0`)
  - NOT_EMPTY, with the FULL sub-case (`words_used == 2**POINTER_WIDTH`)

## Timing
- Reset (asynchronous assert, released on a clock edge) drives:
  - `word_out_valid` = 0
  - `word_out` = 0 (storage entry 0 cleared)
  - `words_used` = 0
  - `overflow_count` = 0
  - both pointers = 0
- Reset mid-operation discards all queued words immediately and clears `overflow_count`.
- Input strobes sampled in the same cycle as `reset` are ignored.
- Latency: a word strobed at edge N is visible with `word_out_valid = 1` after edge N (1 cycle). The empty FIFO has no bypass.
- A pop at edge N exposes the next entry after edge N.
- Full throughput: one push and one pop per cycle are sustained indefinitely.
- Boundary cases:
  - Full + strobe + pop in the same cycle: the write is accepted, `words_used` stays at max, no drop.
  - Empty + strobe + `word_out_ready`: only the push occurs, since valid was 0.
  - Pointer wrap from `2**POINTER_WIDTH - 1` to 0 must preserve ordering.
  - `overflow_count` at 16'hFFFF stays at 16'hFFFF on further drops.

## Test plan
- Reset behaviour: hold `reset` high for 3 cycles with `data_out_ready` strobing. Required: all outputs 0 throughout; `words_used` = 0 after release.
- Single word: strobe lanes `{8'h04, 8'h03, 8'h02, 8'h01}` (lanes [3..0]) with `word_out_ready` = 0.
  - Next cycle: `word_out_valid` = 1, `word_out` = 32'h04030201, `words_used` = 1.
  - Value held for 5 cycles; raising ready pops it and `words_used` returns to 0.
- Fill and overflow (POINTER_WIDTH=4): 18 strobes with incrementing lane-0 values 0..17 and ready = 0.
  - Required: `words_used` = 16 and `overflow_count` = 2.
  - Draining yields lane-0 values 0..15 in order.
- Full with simultaneous push and pop: fill to 16, then assert ready and strobe for 20 cycles.
  - Required: `words_used` stays 16 and `overflow_count` stays 0.
  - The output sequence is contiguous with no gap, and ordering holds across pointer wrap.
- Saturation: force 65 540 drops while full. Required: `overflow_count` = 16'hFFFF.
- Asynchronous reset mid-stream: assert `reset` between edges with 7 words queued. Required: `word_out_valid` and `words_used` reach 0 before the next edge; old words never reappear.
